// File: rtl/imem_load_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : imem_load_ctrl
// Purpose  : Boot/reload controller for the RV32I instruction memory. Writes a
//            loader word stream from word 0 upward, pads the rest of the array
//            with NOP, holds the pipeline until the image is complete, then
//            qualifies every IF-stage fetch (bad PCs return NOP + fault).
// Ports    : clk, rst             - clock, async active-high reset
//            ld_start/ld_count    - begin a (re)load of ld_count words
//            ld_valid/ld_data     - loader word stream, ld_ready handshake
//            mem_we/waddr/wdata   - registered instruction-memory write port
//            pc_addr/mem_rdata    - IF-stage PC and raw memory read data
//            inst/fetch_fault     - qualified instruction and fault flag
//            cpu_hold/load_done   - pipeline stall and RUN indication
// Revision : 1.0 - initial release
// ============================================================================
module imem_load_ctrl #(
  parameter int unsigned ADDR_W   = 5,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ld_start,
  input  logic [ADDR_W:0]   ld_count,
  input  logic              ld_valid,
  input  logic [31:0]       ld_data,
  output logic              ld_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       pc_addr,
  input  logic [31:0]       mem_rdata,
  output logic [31:0]       inst,
  output logic              cpu_hold,
  output logic              load_done,
  output logic              fetch_fault
);

  // DEPTH expressed in the (ADDR_W+1)-bit pointer/count width.
  localparam logic [ADDR_W:0] DEPTH_W = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] ONE_W   = {{ADDR_W{1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_FILL = 2'd2,
    S_RUN  = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W:0]   wp_q, wp_d;
  logic [ADDR_W:0]   rc_q, rc_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              hold_q;
  logic [ADDR_W:0]   w_start_cnt;
  logic              w_pc_ok;
  logic              w_pc_unused;

  // Word pointer and remaining count are one bit wider than the address so
  // that a full image (wp == DEPTH) is representable without wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      wp_q    <= '0;
      rc_q    <= '0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      hold_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      wp_q    <= wp_d;
      rc_q    <= rc_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      // Registered decode of the next state: releases on the first RUN cycle.
      hold_q  <= (state_d != S_RUN);
    end
  end

  always_comb begin
    state_d     = state_q;
    wp_d        = wp_q;
    rc_d        = rc_q;
    we_d        = 1'b0;
    waddr_d     = waddr_q;
    wdata_d     = wdata_q;
    w_start_cnt = (ld_count > DEPTH_W) ? DEPTH_W : ld_count;

    case (state_q)
      S_IDLE, S_RUN: begin
        if (ld_start) begin
          rc_d    = w_start_cnt;
          wp_d    = '0;
          state_d = (w_start_cnt != '0) ? S_LOAD : S_FILL;
        end
      end
      S_LOAD: begin
        if (rc_q == '0) begin
          // Full image just written: one drain cycle so the last write lands
          // before RUN, with no NOP padding.
          state_d = S_RUN;
        end else if (ld_valid) begin
          we_d    = 1'b1;
          waddr_d = wp_q[ADDR_W-1:0];
          wdata_d = ld_data;
          wp_d    = wp_q + ONE_W;
          rc_d    = rc_q - ONE_W;
          if ((rc_q == ONE_W) && (wp_q != (DEPTH_W - ONE_W))) begin
            state_d = S_FILL;
          end
        end
      end
      S_FILL: begin
        if (wp_q == DEPTH_W) begin
          // Last NOP write is on the port this cycle; run from the next one.
          state_d = S_RUN;
        end else begin
          we_d    = 1'b1;
          waddr_d = wp_q[ADDR_W-1:0];
          wdata_d = NOP_INST;
          wp_d    = wp_q + ONE_W;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign ld_ready  = (state_q == S_LOAD) && (rc_q != '0);
  assign mem_we    = we_q;
  assign mem_waddr = waddr_q;
  assign mem_wdata = wdata_q;
  assign cpu_hold  = hold_q;
  assign load_done = (state_q == S_RUN);

  // Fetch is valid only for word-aligned PCs that fall inside the array.
  assign w_pc_ok     = (pc_addr[1:0] == 2'b00) && (pc_addr[31:ADDR_W+2] == '0);
  assign inst        = (load_done && w_pc_ok) ? mem_rdata : NOP_INST;
  assign fetch_fault = load_done && !w_pc_ok;

  // The word-index bits go straight to the memory outside this block.
  assign w_pc_unused = ^pc_addr[ADDR_W+1:2];

endmodule
`default_nettype wire

// File: tb/tb_imem_load_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_imem_load_ctrl
// Purpose  : Self-checking bench for imem_load_ctrl. Expected memory writes
//            are queued as stimulus is issued; a negedge monitor pops and
//            compares each write the DUT presents. Fetch, hold and handshake
//            behaviour are checked directly against hand-computed values.
// Revision : 1.0 - initial release
// ============================================================================
module tb_imem_load_ctrl;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        rst;
  logic        ld_start;
  logic [5:0]  ld_count;
  logic        ld_valid;
  logic [31:0] ld_data;
  logic        ld_ready;
  logic        mem_we;
  logic [4:0]  mem_waddr;
  logic [31:0] mem_wdata;
  logic [31:0] pc_addr;
  logic [31:0] mem_rdata;
  logic [31:0] inst;
  logic        cpu_hold;
  logic        load_done;
  logic        fetch_fault;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int w31_cyc = -100;

  logic [36:0] exp_q[$];
  logic [36:0] exp_e;
  logic [31:0] words [0:39];
  logic [31:0] mem [0:31];

  imem_load_ctrl #(.ADDR_W(5), .NOP_INST(32'h0000_0013)) dut (
    .clk         (clk),
    .rst         (rst),
    .ld_start    (ld_start),
    .ld_count    (ld_count),
    .ld_valid    (ld_valid),
    .ld_data     (ld_data),
    .ld_ready    (ld_ready),
    .mem_we      (mem_we),
    .mem_waddr   (mem_waddr),
    .mem_wdata   (mem_wdata),
    .pc_addr     (pc_addr),
    .mem_rdata   (mem_rdata),
    .inst        (inst),
    .cpu_hold    (cpu_hold),
    .load_done   (load_done),
    .fetch_fault (fetch_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Instruction memory model: synchronous write, combinational read.
  always @(posedge clk) if (mem_we) mem[mem_waddr] <= mem_wdata;
  assign mem_rdata = mem[pc_addr[6:2]];

  // Write monitor / scoreboard.
  always @(negedge clk) begin
    if (!rst && mem_we) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_write: got addr=%0d data=%h, required no write",
                 mem_waddr, mem_wdata);
      end else begin
        exp_e = exp_q.pop_front();
        if ({mem_waddr, mem_wdata} !== exp_e) begin
          bad++;
          $display("FAIL mem_write: got addr=%0d data=%h, required addr=%0d data=%h",
                   mem_waddr, mem_wdata, exp_e[36:32], exp_e[31:0]);
        end
      end
      if (mem_waddr == 5'd31) w31_cyc = cyc;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input logic [5:0] cnt);
    ld_count = cnt;
    ld_start = 1'b1;
    tick();
    ld_start = 1'b0;
  endtask

  // Drive n handshakes of words[0..n-1]; optionally toggle valid 1,0,1,0.
  task automatic send(input int n, input bit toggle, input bit chk_drop);
    int hs   = 0;
    int step = 0;
    while (hs < n && step < 200) begin
      ld_valid = toggle ? (step % 2 == 0) : 1'b1;
      ld_data  = ld_valid ? words[hs] : 32'hDEAD_BEEF;
      chk("ld_ready_in_load", 32'(ld_ready), 32'd1);
      if (ld_valid) begin
        exp_q.push_back({hs[4:0], words[hs]});
        hs++;
      end
      step++;
      tick();
    end
    ld_valid = 1'b0;
    if (chk_drop) chk("ld_ready_drop", 32'(ld_ready), 32'd0);
  endtask

  task automatic push_fill(input int from);
    for (int i = from; i < 32; i++) begin
      exp_q.push_back({i[4:0], NOP});
    end
  endtask

  // Wait (bounded) for the pipeline release, then check its timing.
  task automatic wait_run(input string name);
    int i = 0;
    while (cpu_hold && i < 200) begin
      tick();
      i++;
    end
    chk({name, "_hold_release"}, 32'(cpu_hold), 32'd0);
    chk({name, "_release_timing"}, 32'(cyc), 32'(w31_cyc + 1));
    chk({name, "_all_writes_seen"}, 32'(exp_q.size()), 32'd0);
    chk({name, "_load_done"}, 32'(load_done), 32'd1);
  endtask

  task automatic fetch(input string name, input logic [31:0] pc,
                       input logic [31:0] exp_inst, input logic exp_fault);
    pc_addr = pc;
    #1;
    chk({name, "_inst"}, inst, exp_inst);
    chk({name, "_fault"}, 32'(fetch_fault), 32'(exp_fault));
  endtask

  initial begin
    rst = 1'b1; ld_start = 1'b0; ld_count = '0; ld_valid = 1'b0;
    ld_data = '0; pc_addr = '0;
    #3;
    chk("rst_cpu_hold", 32'(cpu_hold), 32'd1);
    chk("rst_ld_ready", 32'(ld_ready), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_waddr", 32'(mem_waddr), 32'd0);
    chk("rst_wdata", mem_wdata, 32'd0);
    chk("rst_load_done", 32'(load_done), 32'd0);
    chk("rst_inst", inst, NOP);
    chk("rst_fault", 32'(fetch_fault), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    tick();

    // 1: three words back-to-back then NOP padding.
    words[0] = 32'h0050_0113; words[1] = 32'h00C0_0193; words[2] = 32'hFF71_8393;
    start(6'd3);
    send(3, 1'b0, 1'b1);
    push_fill(3);
    wait_run("t1");
    fetch("t1_pc4", 32'h4, 32'h00C0_0193, 1'b0);
    fetch("t1_pc8", 32'h8, 32'hFF71_8393, 1'b0);

    // 2: reload from RUN, valid toggling.
    words[0] = 32'hA000_0001; words[1] = 32'hA000_0002;
    words[2] = 32'hA000_0003; words[3] = 32'hA000_0004;
    start(6'd4);
    chk("t2_reload_hold", 32'(cpu_hold), 32'd1);
    chk("t2_reload_done", 32'(load_done), 32'd0);
    send(4, 1'b1, 1'b1);
    push_fill(4);
    wait_run("t2");

    // 3: count above depth saturates; full image, no padding.
    for (int i = 0; i < 32; i++) words[i] = 32'h1000_0000 + 32'(i);
    start(6'd40);
    send(32, 1'b0, 1'b1);
    wait_run("t3");

    // 4: fetch qualification.
    fetch("t4_pc82", 32'h82, NOP, 1'b1);
    fetch("t4_pc80", 32'h80, NOP, 1'b1);
    fetch("t4_pc7c", 32'h7C, 32'h1000_001F, 1'b0);
    fetch("t4_pc04", 32'h04, 32'h1000_0001, 1'b0);
    fetch("t4_pc_hi", 32'h8000_0000, NOP, 1'b1);

    // 5: zero count fills everything with NOP; start and valid in FILL ignored.
    start(6'd0);
    chk("t5_ready_fill", 32'(ld_ready), 32'd0);
    push_fill(0);
    tick();
    ld_count = 6'd3; ld_start = 1'b1; ld_valid = 1'b1; ld_data = 32'h1234_5678;
    tick();
    ld_start = 1'b0; ld_valid = 1'b0;
    wait_run("t5");
    fetch("t5_pc00", 32'h00, NOP, 1'b0);
    fetch("t5_pc40", 32'h40, NOP, 1'b0);
    fetch("t5_pc7c", 32'h7C, NOP, 1'b0);

    // 6: asynchronous reset mid-LOAD.
    words[0] = 32'hB000_0001; words[1] = 32'hB000_0002;
    start(6'd5);
    send(2, 1'b0, 1'b0);
    chk("t6_pre_we", 32'(mem_we), 32'd1);
    #1;
    rst = 1'b1;
    #1;
    chk("t6_async_we", 32'(mem_we), 32'd0);
    chk("t6_async_ready", 32'(ld_ready), 32'd0);
    chk("t6_async_done", 32'(load_done), 32'd0);
    chk("t6_async_hold", 32'(cpu_hold), 32'd1);
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    ld_valid = 1'b1; ld_data = 32'hCAFE_0000;
    tick(); tick(); tick();
    chk("t6_idle_ready", 32'(ld_ready), 32'd0);
    chk("t6_idle_we", 32'(mem_we), 32'd0);
    chk("t6_idle_hold", 32'(cpu_hold), 32'd1);
    ld_valid = 1'b0;
    start(6'd0);
    push_fill(0);
    wait_run("t6");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/imem_load_ctrl.md
Name: imem_load_ctrl

Overview:
Boot/reload controller that owns the write side of the RV32I instruction memory and gates the fetch side.
- Accepts a word stream from a program loader and writes it from word 0 upward.
- Pads the remaining words with NOP (0x00000013).
- Holds the pipeline in stall until the image is complete.
- While the core runs, qualifies each fetch: out-of-range or misaligned PCs return NOP and raise a fault flag.
- Sits between the loader/debug interface, the instruction memory array, and the IF stage.

Parameters:
ADDR_W, 5, word-address width; memory depth DEPTH = 2^ADDR_W (32 words).
NOP_INST, 32'h00000013, fill word and fetch substitute (addi x0,x0,0).

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  asynchronous, active-high reset.
ld_start  input  1  one-cycle pulse that begins a load; latches ld_count.
ld_count  input  ADDR_W+1  number of words to load, 0..DEPTH; values above DEPTH saturate to DEPTH.
ld_valid  input  1  loader word valid.
ld_data  input  32  loader instruction word.
ld_ready  output  1  controller accepts a word this cycle.
mem_we  output  1  instruction-memory write enable (registered).
mem_waddr  output  ADDR_W  write word address (registered).
mem_wdata  output  32  write data (registered).
pc_addr  input  32  IF-stage byte PC.
mem_rdata  input  32  instruction memory read data at word pc_addr[ADDR_W+1:2] (combinational read).
inst  output  32  qualified instruction to IF stage.
cpu_hold  output  1  stall/hold for the whole pipeline.
load_done  output  1  high while in RUN.
fetch_fault  output  1  PC misaligned or beyond memory in RUN (combinational).

Behaviour:
Reset values (async, immediate):
- state = IDLE; cpu_hold = 1; ld_ready = 0; mem_we = 0; mem_waddr = 0; mem_wdata = 0; load_done = 0.
- Word pointer wp = 0; remaining count rc = 0.

States:
- IDLE: cpu_hold = 1. ld_start latches rc = min(ld_count, DEPTH) and sets wp = 0. Next state is LOAD if rc ≠ 0, otherwise FILL.
- LOAD: ld_ready = 1.
  - On a handshake (ld_valid & ld_ready), the next edge drives mem_we = 1, mem_waddr = wp, mem_wdata = ld_data, then increments wp and decrements rc.
  - No handshake gives mem_we = 0 next cycle.
  - The handshake that takes rc to 0 moves to FILL; ld_ready drops in the same cycle the state changes.
  - If wp reaches DEPTH at that handshake (full image), skip FILL and go to RUN.
- FILL: ld_ready = 0. Each cycle registers mem_we = 1, mem_waddr = wp, mem_wdata = NOP_INST and increments wp. After writing word DEPTH-1, go to RUN. wp never wraps.
- RUN: cpu_hold = 0, load_done = 1, mem_we = 0.
  - ld_start in RUN begins a reload: cpu_hold = 1 and load_done = 0 from the next edge. Entry rules are the same as from IDLE.
- cpu_hold is a registered decode of state. It deasserts on the first RUN cycle, one cycle after the last memory write is issued, so the write has landed before the first fetch.

Fetch qualification:
- RUN and pc_addr[1:0] = 0 and pc_addr[31:ADDR_W+2] = 0: inst = mem_rdata, fetch_fault = 0.
- RUN and either condition fails: inst = NOP_INST, fetch_fault = 1.
- Any non-RUN state: inst = NOP_INST, fetch_fault = 0.

Boundary rules:
- ld_start in LOAD or FILL is ignored; the load in progress completes.
- ld_valid outside LOAD is ignored with no write.
- ld_count = 0 fills all DEPTH words with NOP. ld_count = DEPTH produces no FILL cycles.
- Reset mid-LOAD or mid-FILL aborts immediately: mem_we = 0, and memory contents are left as partially written.
- Loader data is never dropped: a word is consumed only on a handshake.

Test Plan:
1. Reset, then ld_start with ld_count = 3, words 0x00500113, 0x00C00193, 0xFF718393 sent back-to-back -> writes at addresses 0, 1, 2, then NOP writes at 3..31 on 29 consecutive cycles; cpu_hold falls exactly one cycle after the address-31 write; pc_addr = 4 gives inst = 0x00C00193.
2. ld_count = 4 with ld_valid toggling 1, 0, 1, 0 -> mem_we follows the handshakes with one-cycle delay; exactly 4 data writes with no duplicates; ld_ready stays 1 until the 4th handshake.
3. ld_count = 40 (saturates to 32) -> 32 data writes, no FILL cycles, RUN on the cycle after the address-31 write.
4. In RUN, pc_addr = 0x82 -> inst = 0x00000013, fetch_fault = 1; pc_addr = 0x80 -> NOP, fault = 1; pc_addr = 0x7C -> inst = mem_rdata, fault = 0.
5. ld_count = 0 -> 32 NOP writes, then RUN; every in-range fetch returns 0x00000013.
6. Reset asserted asynchronously mid-LOAD after 2 words -> mem_we, ld_ready and load_done go to 0 and cpu_hold to 1 without waiting for a clock edge; IDLE is held until ld_start. A reload issued in RUN reasserts cpu_hold on the next edge.
